dec_out_mux_fifo: RTL and testbench
===================================

Name: dec_out_mux_fifo

Overview:
Parametrised output stage for the decryption system. It selects one of NUM_CH decryptor output channels and buffers the selected bytes in a DEPTH-entry FIFO. Bytes are delivered on a ready/valid output interface with a programmable minimum idle gap between beats. It replaces the fixed 3-channel, unbuffered output mux and adds back-pressure, overflow reporting and safe channel switching (drain before switch).

Parameters:
D_WIDTH, 8, width of one data word.
NUM_CH, 3, number of decryptor input channels (1..2**SEL_W-1).
SEL_W, 2, width of select. Any select value >= NUM_CH disables the block.
DEPTH, 4, FIFO entries. Power of 2, >= 2.
GAP, 1, minimum idle cycles after each accepted output beat. 0 allows back-to-back beats.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
select  in  SEL_W  requested channel index; >= NUM_CH means off
data_i  in  NUM_CH*D_WIDTH  concatenated channel data; channel k occupies bits [k*D_WIDTH +: D_WIDTH]
valid_i  in  NUM_CH  per-channel data-valid
data_o  out  D_WIDTH  output word; 0 whenever valid_o is low
valid_o  out  1  output word valid
ready_i  in  1  downstream accepts; a beat transfers on an edge where valid_o && ready_i
busy_o  out  1  high when FIFO count != 0 or valid_o is high
overflow_o  out  1  sticky; set when a selected input word is dropped because the FIFO is full
act_sel_o  out  SEL_W  currently active channel

Behaviour:
- Reset (async, rst_n low): FIFO pointers/count = 0, data_o = 0, valid_o = 0, overflow_o = 0, gap counter = 0, act_sel = all ones (off), state OFF. All outputs take these values immediately, without waiting for a clock edge.
- States (of act_sel vs select):
  - RUN: act_sel < NUM_CH and select == act_sel.
  - DRAIN: select != act_sel and (count != 0 or valid_o).
  - SWITCH: select != act_sel and count == 0 and !valid_o. At the next edge act_sel <= select, giving RUN or OFF.
  - OFF: act_sel >= NUM_CH and select == act_sel.
- Capture: a push occurs only in RUN when valid_i[act_sel] is high. Words presented in DRAIN, SWITCH or OFF are discarded silently and do not set overflow_o.
- Full rule: a push is rejected when the registered count == DEPTH, even if a pop happens on the same edge. A rejected push sets overflow_o (sticky until reset). FIFO contents are unchanged.
- Output register:
  - Loads the FIFO head (pop) when count != 0, gap counter == 0, and (!valid_o or ready_i).
  - On a transfer with no reload, valid_o <= 0 and data_o <= 0.
  - On every transfer, the gap counter loads GAP. It decrements each cycle while nonzero.
  - When GAP > 0, a transfer edge never reloads; the next load waits for the gap to expire.
- Latency: a word pushed at edge k can appear on data_o/valid_o after edge k+1 at the earliest (2 edges from input sample to output).
- Throughput: with ready_i held high, one beat per GAP+1 cycles. GAP=1 gives the legacy 1-high/1-low valid pattern.
- Back-pressure: while valid_o && !ready_i, data_o and valid_o hold stable.
- Simultaneous push and pop: count unchanged (only when count < DEPTH, per the full rule).
- Pointers wrap modulo DEPTH. The count register is $clog2(DEPTH)+1 bits wide.
- Select changes mid-stream:
  - Every buffered word of the old channel is delivered before act_sel changes.
  - Changing select back to act_sel during DRAIN returns directly to RUN; no words are lost.
- busy_o and act_sel_o are combinational from registers only.

Test Plan:
1. Reset, select=0, ready_i=1, GAP=1; valid_i[0] pulses with 0x41, 0x42, 0x43 on consecutive cycles -> valid_o high on alternate cycles carrying 0x41, 0x42, 0x43 in order; first beat 2 edges after the 0x41 sample; overflow_o stays 0.
2. select=1, ready_i=0, DEPTH=4; push 6 words 0x10..0x15 on channel 1 -> 0x10 sits in the output register, 0x11..0x14 fill the FIFO, 0x15 is dropped and overflow_o=1. Raising ready_i delivers 0x10..0x14 only.
3. Push 3 words on channel 0 with ready_i=0, then set select=2 and drive valid_i[2] with 0x55 -> state DRAIN, 0x55 discarded. After ready_i=1, the 3 channel-0 words are output, then act_sel_o=2 one edge after busy_o falls, and subsequent channel-2 words pass.
4. select=3 (NUM_CH=3) with all valid_i high -> valid_o=0, data_o=0, busy_o=0, act_sel_o=3, overflow_o unchanged.
5. GAP=0, ready_i=1, a continuous valid_i[0] stream -> valid_o held high, one new word per cycle, count never exceeds 1. Toggling ready_i low for 2 cycles holds data_o stable with no loss.
6. Assert rst_n=0 asynchronously mid-burst with FIFO count=3 and overflow_o=1 -> all outputs clear before the next clk edge. After release, no stale words appear.

Source files
------------

// File: rtl/dec_out_mux_fifo.sv
// Output stage of the decryption system: picks one channel, buffers it in a small FIFO and
// delivers bytes on ready/valid with a minimum idle gap, draining fully before any channel switch.
module dec_out_mux_fifo #(
    parameter int D_WIDTH = 8,
    parameter int NUM_CH  = 3,
    parameter int SEL_W   = 2,
    parameter int DEPTH   = 4,
    parameter int GAP     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SEL_W-1:0]          select,
    input  logic [NUM_CH*D_WIDTH-1:0] data_i,
    input  logic [NUM_CH-1:0]         valid_i,
    output logic [D_WIDTH-1:0]        data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      busy_o,
    output logic                      overflow_o,
    output logic [SEL_W-1:0]          act_sel_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [SEL_W-1:0] CH_LIMIT = SEL_W'(NUM_CH);
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_DRAIN, ST_SWITCH} state_t;

    state_t             state;
    logic [SEL_W-1:0]   act_sel;
    logic [SEL_W-1:0]   act_sel_nxt;
    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [GW-1:0]      gap_cnt;
    logic [D_WIDTH-1:0] ch_data;
    logic               ch_valid;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               xfer;
    logic               gap_ok;

    assign busy_o    = (count != '0) || valid_o;
    assign act_sel_o = act_sel;

    // NOTE: every signal gets a default at the top of the block, so no path can infer a latch.
    always_comb begin
        ch_data  = '0;
        ch_valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (act_sel == SEL_W'(k)) begin
                ch_data  = data_i[k*D_WIDTH +: D_WIDTH];
                ch_valid = valid_i[k];
            end
        end
    end

    // Channel state is decoded from the active-select register against the requested select.
    always_comb begin
        state       = ST_OFF;
        act_sel_nxt = act_sel;
        if (select == act_sel) begin
            state = (act_sel < CH_LIMIT) ? ST_RUN : ST_OFF;
        end else if (busy_o) begin
            state = ST_DRAIN;
        end else begin
            state       = ST_SWITCH;
            act_sel_nxt = select;
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_sel <= '1;
        end else begin
            act_sel <= act_sel_nxt;
        end
    end

    // The counter expiring on this edge already satisfies the idle gap, giving one beat per GAP+1.
    assign gap_ok   = (gap_cnt <= GW'(1));
    assign xfer     = valid_o && ready_i;
    assign push_req = (state == ST_RUN) && ch_valid;
    assign push     = push_req && (count != FULL_CNT);
    assign pop      = (count != '0) && gap_ok && (!valid_o || (xfer && (GAP == 0)));

    // NOTE: the storage array carries no reset; pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ch_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            gap_cnt    <= '0;
            data_o     <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (push_req && !push) begin
                overflow_o <= 1'b1;
            end
            if (pop) begin
                data_o  <= mem[rd_ptr];
                valid_o <= 1'b1;
            end else if (xfer) begin
                data_o  <= '0;
                valid_o <= 1'b0;
            end
            if (xfer) begin
                gap_cnt <= GW'(GAP);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end
endmodule

// File: tb/tb_dec_out_mux_fifo.sv
// Bench for dec_out_mux_fifo: a GAP=1 and a GAP=0 instance share stimulus and are each
// compared every cycle against a queue-based reference model.
module tb_dec_out_mux_fifo;
    localparam int NUM_CH = 3;
    localparam int DEPTH  = 4;
    localparam int NI     = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  select  = '0;
    logic [23:0] data_i  = '0;
    logic [2:0]  valid_i = '0;
    logic        ready_i = 1'b0;

    logic [7:0] data_o_g1, data_o_g0;
    logic       valid_o_g1, valid_o_g0;
    logic       busy_o_g1, busy_o_g0;
    logic       overflow_o_g1, overflow_o_g0;
    logic [1:0] act_sel_o_g1, act_sel_o_g0;

    dec_out_mux_fifo #(.D_WIDTH(8), .NUM_CH(NUM_CH), .SEL_W(2), .DEPTH(DEPTH), .GAP(1)) u_gap1 (
        .clk(clk), .rst_n(rst_n), .select(select), .data_i(data_i), .valid_i(valid_i),
        .data_o(data_o_g1), .valid_o(valid_o_g1), .ready_i(ready_i), .busy_o(busy_o_g1),
        .overflow_o(overflow_o_g1), .act_sel_o(act_sel_o_g1)
    );

    dec_out_mux_fifo #(.D_WIDTH(8), .NUM_CH(NUM_CH), .SEL_W(2), .DEPTH(DEPTH), .GAP(0)) u_gap0 (
        .clk(clk), .rst_n(rst_n), .select(select), .data_i(data_i), .valid_i(valid_i),
        .data_o(data_o_g0), .valid_o(valid_o_g0), .ready_i(ready_i), .busy_o(busy_o_g0),
        .overflow_o(overflow_o_g0), .act_sel_o(act_sel_o_g0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: index 0 mirrors the GAP=1 instance, index 1 the GAP=0 instance.
    logic [7:0] mq [NI][$];
    logic       m_ov  [NI];
    logic [7:0] m_od  [NI];
    logic       m_ovf [NI];
    logic [1:0] m_act [NI];
    int         m_last[NI];
    int         cyc = 0;

    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mq[i].delete();
            m_ov[i]   = 1'b0;
            m_od[i]   = '0;
            m_ovf[i]  = 1'b0;
            m_act[i]  = 2'b11;
            m_last[i] = -1000;
        end
    endtask

    // One clock edge: the beat leaves on a transfer, the next word may load once GAP cycles
    // have passed since the last transfer, and the sampled word joins the back of the queue.
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            logic       busy;
            logic       xfer;
            logic       have_new;
            logic [7:0] new_b;
            int         a;
            busy     = (mq[i].size() != 0) || m_ov[i];
            xfer     = m_ov[i] && ready_i;
            have_new = 1'b0;
            new_b    = '0;
            a        = int'(m_act[i]);
            if (xfer) m_last[i] = cyc;
            if (select == m_act[i]) begin
                if (a < NUM_CH && valid_i[a]) begin
                    if (mq[i].size() == DEPTH) begin
                        m_ovf[i] = 1'b1;
                    end else begin
                        have_new = 1'b1;
                        new_b    = data_i[a*8 +: 8];
                    end
                end
            end else if (!busy) begin
                m_act[i] = select;
            end
            if (mq[i].size() != 0 && (!m_ov[i] || xfer) && cyc >= m_last[i] + gap_of(i)) begin
                m_od[i] = mq[i].pop_front();
                m_ov[i] = 1'b1;
            end else if (xfer) begin
                m_ov[i] = 1'b0;
                m_od[i] = '0;
            end
            if (have_new) mq[i].push_back(new_b);
        end
        cyc++;
    endtask

    task automatic compare_outputs(input string ph);
        check({ph, " g1 data_o"},     32'(data_o_g1),     32'(m_od[0]));
        check({ph, " g1 valid_o"},    32'(valid_o_g1),    32'(m_ov[0]));
        check({ph, " g1 busy_o"},     32'(busy_o_g1),     32'((mq[0].size() != 0) || m_ov[0]));
        check({ph, " g1 overflow_o"}, 32'(overflow_o_g1), 32'(m_ovf[0]));
        check({ph, " g1 act_sel_o"},  32'(act_sel_o_g1),  32'(m_act[0]));
        check({ph, " g0 data_o"},     32'(data_o_g0),     32'(m_od[1]));
        check({ph, " g0 valid_o"},    32'(valid_o_g0),    32'(m_ov[1]));
        check({ph, " g0 busy_o"},     32'(busy_o_g0),     32'((mq[1].size() != 0) || m_ov[1]));
        check({ph, " g0 overflow_o"}, 32'(overflow_o_g0), 32'(m_ovf[1]));
        check({ph, " g0 act_sel_o"},  32'(act_sel_o_g0),  32'(m_act[1]));
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_step();
        #1;
        compare_outputs(ph);
    endtask

    task automatic drive(input logic [1:0] sel, input logic [2:0] vin, input logic [23:0] din,
                         input logic rdy);
        select  = sel;
        valid_i = vin;
        data_i  = din;
        ready_i = rdy;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 compare_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Legacy pattern: three consecutive words, alternate-cycle delivery.
        drive(2'd0, 3'b000, 24'h0, 1'b1);
        step("t1 switch");
        for (int j = 0; j < 3; j++) begin
            drive(2'd0, 3'b001, {16'h0, 8'(8'h41 + j)}, 1'b1);
            step("t1 push");
        end
        drive(2'd0, 3'b000, 24'h0, 1'b1);
        for (int j = 0; j < 8; j++) step("t1 drain");

        // Drain before switch, including a return to the old channel mid-drain.
        for (int j = 0; j < 3; j++) begin
            drive(2'd0, 3'b001, {16'h0, 8'(8'h31 + j)}, 1'b0);
            step("t3 push");
        end
        for (int j = 0; j < 2; j++) begin
            drive(2'd2, 3'b100, {8'h55, 16'h0}, 1'b0);
            step("t3 drain hold");
        end
        drive(2'd0, 3'b001, {16'h0, 8'h34}, 1'b0);
        step("t3 back to run");
        drive(2'd0, 3'b000, 24'h0, 1'b0);
        step("t3 idle");
        for (int j = 0; j < 12; j++) begin
            drive(2'd2, 3'b100, {8'h55, 16'h0}, 1'b1);
            step("t3 drain");
        end
        for (int j = 0; j < 4; j++) begin
            drive(2'd2, 3'b100, {8'(8'h60 + j), 16'h0}, 1'b1);
            step("t3 ch2");
        end
        drive(2'd2, 3'b000, 24'h0, 1'b1);
        for (int j = 0; j < 8; j++) step("t3 tail");
        check("t3 act_sel after switch", 32'(act_sel_o_g1), 32'd2);

        // Out-of-range select disables the block.
        for (int j = 0; j < 6; j++) begin
            drive(2'd3, 3'b111, 24'($urandom), 1'b1);
            step("t4 off");
        end
        check("t4 act_sel off", 32'(act_sel_o_g1), 32'd3);
        check("t4 valid_o off", 32'(valid_o_g0), 32'd0);

        // Continuous stream with a two-cycle back-pressure window.
        for (int j = 0; j < 14; j++) begin
            drive(2'd0, 3'b001, {16'h0, 8'(8'h70 + j)}, (j == 6 || j == 7) ? 1'b0 : 1'b1);
            step("t5 stream");
        end
        drive(2'd0, 3'b000, 24'h0, 1'b1);
        for (int j = 0; j < 16; j++) step("t5 drain");

        // Overflow: six words into a stalled output.
        drive(2'd1, 3'b000, 24'h0, 1'b0);
        step("t2 switch");
        for (int j = 0; j < 6; j++) begin
            drive(2'd1, 3'b010 | 3'($urandom_range(0, 7) & 5), {8'hAA, 8'(8'h10 + j), 8'hBB}, 1'b0);
            step("t2 push");
        end
        check("t2 overflow set", 32'(overflow_o_g0), 32'd1);
        check("t2 head held", 32'(data_o_g0), 32'h10);
        drive(2'd1, 3'b000, 24'h0, 1'b1);
        for (int j = 0; j < 14; j++) step("t2 drain");

        // Asynchronous reset mid-burst with three words buffered.
        for (int j = 0; j < 4; j++) begin
            drive(2'd1, 3'b010, {8'h0, 8'(8'h80 + j), 8'h0}, 1'b0);
            step("t6 push");
        end
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_outputs("t6 async");
        @(posedge clk);
        #1;
        compare_outputs("t6 held");
        rst_n = 1'b1;
        drive(2'd1, 3'b000, 24'h0, 1'b1);
        for (int j = 0; j < 6; j++) step("t6 after");
        check("t6 no stale beat", 32'(valid_o_g1), 32'd0);

        // Randomised traffic with occasional channel changes.
        drive(2'd0, 3'b000, 24'h0, 1'b1);
        for (int j = 0; j < 400; j++) begin
            logic [1:0] sel;
            sel = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : select;
            drive(sel, 3'($urandom), 24'($urandom), ($urandom_range(0, 3) != 0));
            step("rand");
        end
        drive(select, 3'b000, 24'h0, 1'b1);
        for (int j = 0; j < 16; j++) step("final drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
